// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of the SRAM controller: latch one request, hold the command
// until ack or timeout, then pulse ack to the requester. SRAM_ARB_RR_EN selects round-robin.
module sram_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req0,
    input  logic        i_req1,
    input  logic        i_wren0,
    input  logic        i_wren1,
    input  logic [17:0] i_addr0,
    input  logic [17:0] i_addr1,
    input  logic [31:0] i_wdata0,
    input  logic [31:0] i_wdata1,
    input  logic [3:0]  i_bmask0,
    input  logic [3:0]  i_bmask1,
    output logic        o_ack0,
    output logic        o_ack1,
    output logic        o_err0,
    output logic        o_err1,
    output logic [31:0] o_rdata,
    output logic [17:0] o_sram_addr,
    output logic [31:0] o_sram_wdata,
    output logic [3:0]  o_sram_bmask,
    output logic        o_sram_wren,
    output logic        o_sram_rden,
    input  logic [31:0] i_sram_rdata,
    input  logic        i_sram_ack
);

    typedef enum logic [1:0] {StIdle, StCmd, StResp} state_e;

    localparam logic [15:0] CntLast = 16'(TIMEOUT_CYCLES - 1);

    state_e      r_state;
    state_e      w_state_next;
    logic        r_wren;
    logic [17:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_bmask;
    logic        r_grant;
    logic [15:0] r_cnt;
    logic        r_err;
    logic [31:0] r_rdata;
    logic        w_any_req;
    logic        w_win;
    logic        w_timeout;

    assign w_any_req = i_req0 | i_req1;
    assign w_timeout = (r_cnt == CntLast);

`ifdef SRAM_ARB_RR_EN
    // Pointer remembers the last granted port; a tie goes to the other one.
    logic r_ptr;

    always_comb begin
        if (i_req0 && i_req1) begin
            w_win = ~r_ptr;
        end else begin
            w_win = i_req1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_ptr <= 1'b1;
        end else if (r_state == StIdle && w_any_req) begin
            r_ptr <= w_win;
        end
    end
`else
    assign w_win = i_req1;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_any_req) w_state_next = StCmd;
            StCmd:   if (i_sram_ack || w_timeout) w_state_next = StResp;
            StResp:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_wren  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_bmask <= '0;
            r_grant <= 1'b0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_any_req) begin
                        r_grant <= w_win;
                        r_wren  <= w_win ? i_wren1  : i_wren0;
                        r_addr  <= w_win ? i_addr1  : i_addr0;
                        r_wdata <= w_win ? i_wdata1 : i_wdata0;
                        r_bmask <= w_win ? i_bmask1 : i_bmask0;
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                        r_rdata <= '0;
                    end
                end
                StCmd: begin
                    r_cnt <= r_cnt + 16'd1;
                    // A late ack on the timeout cycle still counts as success.
                    if (i_sram_ack) begin
                        r_rdata <= r_wren ? 32'd0 : i_sram_rdata;
                        r_err   <= 1'b0;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_ack0       = 1'b0;
        o_ack1       = 1'b0;
        o_err0       = 1'b0;
        o_err1       = 1'b0;
        o_rdata      = '0;
        o_sram_addr  = '0;
        o_sram_wdata = '0;
        o_sram_bmask = '0;
        o_sram_wren  = 1'b0;
        o_sram_rden  = 1'b0;
        if (r_state == StCmd) begin
            o_sram_addr  = r_addr;
            o_sram_wdata = r_wdata;
            o_sram_bmask = r_bmask;
            o_sram_wren  = r_wren;
            o_sram_rden  = ~r_wren;
        end
        if (r_state == StResp) begin
            o_ack0  = ~r_grant;
            o_ack1  = r_grant;
            o_err0  = r_err & ~r_grant;
            o_err1  = r_err & r_grant;
            o_rdata = r_rdata;
        end
    end

endmodule
